// File: rtl/seg7_pkg.sv
// seg7_pkg: glyph table, blank pattern and FSM encoding shared by the seg7 decoder
package seg7_pkg;
  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;
endpackage

// File: rtl/seg7_glyph_dec.sv
// seg7_glyph_dec: maps an active-low 7-segment pattern to its hex nibble and a legal flag
module seg7_glyph_dec
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       legal
);
  always_comb begin
    nibble = '0;
    legal = 1'b0;
    for (int i = 0; i < 16; i++)
      if (pattern == GLYPH[i]) begin
        nibble = 4'(i);
        legal = 1'b1;
      end
  end
endmodule

// File: rtl/seg7_decode.sv
// seg7_decode: synchronizes two 7-segment digits, waits for a stable sample, decodes to a byte
module seg7_decode
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] d0_in,
  input  logic [6:0] d1_in,
  output logic [7:0] value,
  output logic       valid,
  output logic       err,
  output logic       blank,
  output logic [7:0] err_cnt
);
  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);
  logic [13:0] s1, s2, prev;
  logic [7:0] cnt, cnt_d;
  state_t state, state_d;
  logic fire, same, l0, l1, both_blank, both_legal;
  logic [3:0] n0, n1;
  seg7_glyph_dec u_dec0 (.pattern(prev[6:0]), .nibble(n0), .legal(l0));
  seg7_glyph_dec u_dec1 (.pattern(prev[13:7]), .nibble(n1), .legal(l1));
  assign same = s2 == prev;
  assign both_blank = prev == {BLANK, BLANK};
  assign both_legal = l0 && l1;
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    fire = 1'b0;
    case (state)
      IDLE: begin
        state_d = SETTLE;
        cnt_d = '0;
      end
      SETTLE:
        if (!same) cnt_d = '0;
        else if (cnt >= STABLE) begin
          fire = 1'b1;
          state_d = LOCKED;
        end else cnt_d = cnt + 8'd1;
      LOCKED:
        if (!same) begin
          state_d = SETTLE;
          cnt_d = '0;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= {BLANK, BLANK};
      s2 <= {BLANK, BLANK};
      prev <= {BLANK, BLANK};
      state <= IDLE;
      cnt <= '0;
      value <= '0;
      valid <= 1'b0;
      err <= 1'b0;
      blank <= 1'b0;
      err_cnt <= '0;
    end else begin
      s1 <= {d1_in, d0_in};
      s2 <= s1;
      prev <= s2;
      state <= state_d;
      cnt <= cnt_d;
      valid <= fire && both_legal;
      err <= fire && !both_legal && !both_blank;
      if (fire && both_legal) value <= {n1, n0};
      if (fire && both_blank) blank <= 1'b1;
      else if (state == LOCKED && !same) blank <= 1'b0;
      if (fire && !both_legal && !both_blank && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_seg7_decode.sv
// tb_seg7_decode: directed checks of settle latency, decode, blank, error counting and reset
module tb_seg7_decode;
  logic clk = 1'b0;
  logic rst;
  logic [6:0] d0, d1;
  logic [7:0] value, err_cnt;
  logic valid, err, blank;
  int n_cmp = 0;
  int n_err = 0;
  seg7_decode #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .d0_in(d0), .d1_in(d1),
    .value(value), .valid(valid), .err(err), .blank(blank), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic settle(input string tag, input logic [6:0] a, input logic [6:0] b,
                        input int exp_lat, input logic exp_v, input logic exp_e);
    int lat;
    logic v, e;
    lat = -1;
    v = 1'b0;
    e = 1'b0;
    d1 = a;
    d0 = b;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (valid || err) begin
        lat = k;
        v = valid;
        e = err;
        break;
      end
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    if (lat >= 0) begin
      chk({tag, "_valid"}, 32'(v), 32'(exp_v));
      chk({tag, "_err"}, 32'(e), 32'(exp_e));
      tick();
      chk({tag, "_pulse_end"}, 32'(valid | err), 32'd0);
    end
  endtask
  initial begin
    int pulses, errs, vals;
    rst = 1'b1;
    d0 = 7'h7F;
    d1 = 7'h7F;
    repeat (3) tick();
    chk("rst_value", 32'(value), 32'h00);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_blank", 32'(blank), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b0;
    repeat (12) tick();
    chk("idle_blank", 32'(blank), 32'd1);
    settle("d12", 7'h79, 7'h24, 7, 1'b1, 1'b0);
    chk("d12_value", 32'(value), 32'h12);
    chk("d12_err_cnt", 32'(err_cnt), 32'd0);
    chk("d12_blank", 32'(blank), 32'd0);
    settle("dAF", 7'h08, 7'h0E, 7, 1'b1, 1'b0);
    chk("dAF_value", 32'(value), 32'hAF);
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (valid || err) pulses++;
    end
    chk("hold_no_pulse", 32'(pulses), 32'd0);
    settle("blank", 7'h7F, 7'h7F, -1, 1'b0, 1'b0);
    chk("blank_level", 32'(blank), 32'd1);
    chk("blank_value", 32'(value), 32'hAF);
    settle("d00", 7'h40, 7'h40, 7, 1'b1, 1'b0);
    chk("d00_value", 32'(value), 32'h00);
    chk("d00_blank", 32'(blank), 32'd0);
    settle("ill55", 7'h40, 7'h55, 7, 1'b0, 1'b1);
    chk("ill55_err_cnt", 32'(err_cnt), 32'd1);
    chk("ill55_value", 32'(value), 32'h00);
    settle("half_blank", 7'h7F, 7'h40, 7, 1'b0, 1'b1);
    chk("half_blank_err_cnt", 32'(err_cnt), 32'd2);
    chk("half_blank_level", 32'(blank), 32'd0);
    errs = 0;
    vals = 0;
    d1 = 7'h40;
    for (int i = 0; i < 300; i++) begin
      d0 = i[0] ? 7'h56 : 7'h55;
      repeat (9) begin
        tick();
        if (err) errs++;
        if (valid) vals++;
      end
    end
    chk("sat_err_pulses", 32'(errs), 32'd300);
    chk("sat_no_valid", 32'(vals), 32'd0);
    chk("sat_err_cnt", 32'(err_cnt), 32'd255);
    chk("sat_value", 32'(value), 32'h00);
    pulses = 0;
    d1 = 7'h30;
    d0 = 7'h30;
    repeat (2) begin
      tick();
      if (valid || err) pulses++;
    end
    d0 = 7'h10;
    repeat (2) begin
      tick();
      if (valid || err) pulses++;
    end
    chk("glitch_no_pulse", 32'(pulses), 32'd0);
    settle("d33", 7'h30, 7'h30, 7, 1'b1, 1'b0);
    chk("d33_value", 32'(value), 32'h33);
    chk("d33_err_cnt", 32'(err_cnt), 32'd255);
    d1 = 7'h79;
    d0 = 7'h79;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_value", 32'(value), 32'h00);
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_blank", 32'(blank), 32'd0);
    chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    tick();
    chk("mid_rst_hold_valid", 32'(valid | err), 32'd0);
    rst = 1'b0;
    settle("post_rst", 7'h79, 7'h79, 7, 1'b1, 1'b0);
    chk("post_rst_value", 32'(value), 32'h11);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
